bin2bcd_seq: RTL and testbench

Sequential double-dabble (shift-and-add-3) converter that turns an unsigned WIDTH-bit binary value into DIGITS packed BCD digits over WIDTH clock cycles. It sits directly upstream of the display/BCD datapath and drives the per-digit 4-bit add-3 correction. It accepts one operand per start/done transaction.

---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bin2bcd_seq_if.sv | 15 +
 rtl/bin2bcd_seq_adjust.sv | 12 +
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 tb/tb_bin2bcd_seq.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bin2bcd_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_ADD    = 4'd3;

  // Counter must hold 0..WIDTH-1; a 1-bit counter is the floor.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Operand/result handshake bundle for bin2bcd_seq (start/bin in, busy/done/bcd/overflow out).
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq_adjust.sv
// Per-digit add-3 correction applied before each double-dabble shift.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADJ_THRESH) o_digit = i_digit + ADJ_ADD;
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock over WIDTH cycles.
// Optional sticky overflow detection is enabled with BIN2BCD_OVERFLOW_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  bin2bcd_seq_if.slave   bus
);
  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam int unsigned BW   = DIGIT_W * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_scratch;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Top adjusted bit falls off here; it is only observed by the overflow flag.
  assign w_next = BW'({w_adj, r_shift[WIDTH-1]});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_bcd     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_scratch <= '0;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= CONVERT;
          end
        end
        CONVERT: begin
          r_scratch <= w_next;
          r_shift   <= r_shift << 1;
          r_count   <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_bcd   <= w_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

`ifdef BIN2BCD_OVERFLOW_EN
  logic r_flag;
  logic r_ovf;
  logic w_carry;

  assign w_carry = w_adj[BW-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.start) r_flag <= 1'b0;
    end else begin
      r_flag <= r_flag | w_carry;
      if (r_count == LAST) r_ovf <= r_flag | w_carry;
    end
  end

  assign bus.overflow = r_ovf;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against an arithmetic decimal reference model.
module tb_bin2bcd_seq;
  localparam int unsigned WIDTH = 8;
`ifdef BIN2BCD_OVERFLOW_EN
  localparam int unsigned DIGITS = 2;
  localparam bit          OVF_EN = 1'b1;
`else
  localparam int unsigned DIGITS = 3;
  localparam bit          OVF_EN = 1'b0;
`endif
  localparam int unsigned BW = 4 * DIGITS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    int unsigned lim;
    lim = 1;
    for (int unsigned i = 0; i < DIGITS; i++) lim = lim * 10;
    return OVF_EN && (v >= lim);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input int unsigned v);
    bus.start = 1'b1;
    bus.bin   = WIDTH'(v);
    tick();
    bus.start = 1'b0;
  endtask

  // Waits for done after the start edge; cyc counts edges, bsy counts busy-high cycles.
  task automatic wait_done(output int unsigned cyc, output int unsigned bsy, output bit ok);
    cyc = 0;
    bsy = bus.busy ? 1 : 0;
    ok  = 1'b0;
    while (cyc < 4 * WIDTH) begin
      tick();
      cyc++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) bsy++;
    end
  endtask

  task automatic test_reset();
    bit bad_busy;
    checks++;
    if ({bus.busy, bus.done, bus.bcd, bus.overflow} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b bcd=%h ovf=%b want all 0",
               bus.busy, bus.done, bus.bcd, bus.overflow);
    else passes++;
    reset_n = 1'b1;
    bad_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad_busy = 1'b1;
    end
    checks++;
    if (bad_busy || bus.bcd !== '0)
      $display("FAIL idle_quiet: got busy/done activity=%b bcd=%h want 0/0", bad_busy, bus.bcd);
    else passes++;
  endtask

  task automatic test_latency();
    int unsigned cyc, bsy;
    bit ok;
    start_conv(255);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != WIDTH)
      $display("FAIL latency_255: got ok=%b edges=%0d want edges=%0d", ok, cyc, WIDTH);
    else passes++;
    checks++;
    if (bsy != WIDTH) $display("FAIL busy_len: got %0d want %0d", bsy, WIDTH);
    else passes++;
    checks++;
    if (bus.bcd !== ref_bcd(255) || bus.overflow !== ref_ovf(255))
      $display("FAIL bcd_255: got %h ovf=%b want %h ovf=%b",
               bus.bcd, bus.overflow, ref_bcd(255), ref_ovf(255));
    else passes++;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.bcd !== ref_bcd(255))
      $display("FAIL done_width_hold: got done=%b bcd=%h want 0 %h", bus.done, bus.bcd, ref_bcd(255));
    else passes++;
  endtask

  task automatic test_back_to_back();
    int unsigned cyc, bsy;
    bit ok;
    bus.start = 1'b1;
    bus.bin   = 8'd0;
    tick();
    bus.bin   = 8'd99;
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != WIDTH || bus.bcd !== ref_bcd(0))
      $display("FAIL b2b_zero: got ok=%b edges=%0d bcd=%h want edges=%0d bcd=%h",
               ok, cyc, bus.bcd, WIDTH, ref_bcd(0));
    else passes++;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", bus.busy, bus.done);
    else passes++;
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != WIDTH || bus.bcd !== ref_bcd(99))
      $display("FAIL b2b_99: got ok=%b edges=%0d bcd=%h want edges=%0d bcd=%h",
               ok, cyc, bus.bcd, WIDTH, ref_bcd(99));
    else passes++;
    tick();
  endtask

  task automatic test_start_ignored();
    int unsigned cyc, bsy;
    bit ok, extra;
    start_conv(128);
    tick();
    tick();
    checks++;
    if (bus.bcd !== ref_bcd(99))
      $display("FAIL hold_mid_conv: got %h want %h", bus.bcd, ref_bcd(99));
    else passes++;
    bus.start = 1'b1;
    bus.bin   = 8'd7;
    tick();
    bus.start = 1'b0;
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != WIDTH - 3 || bus.bcd !== ref_bcd(128))
      $display("FAIL ignore_start: got ok=%b edges=%0d bcd=%h want edges=%0d bcd=%h",
               ok, cyc, bus.bcd, WIDTH - 3, ref_bcd(128));
    else passes++;
    extra = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (bus.busy || bus.done) extra = 1'b1;
    end
    checks++;
    if (extra || bus.bcd !== ref_bcd(128))
      $display("FAIL no_second_conv: got activity=%b bcd=%h want 0 %h", extra, bus.bcd, ref_bcd(128));
    else passes++;
  endtask

  task automatic test_reset_mid();
    int unsigned cyc, bsy;
    bit ok;
    start_conv(200);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.bcd, bus.overflow} !== '0)
      $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b want all 0",
               bus.busy, bus.done, bus.bcd, bus.overflow);
    else passes++;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    start_conv(42);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || cyc != WIDTH || bus.bcd !== ref_bcd(42) || bus.overflow !== 1'b0)
      $display("FAIL after_reset_42: got ok=%b edges=%0d bcd=%h ovf=%b want bcd=%h ovf=0",
               ok, cyc, bus.bcd, bus.overflow, ref_bcd(42));
    else passes++;
    tick();
  endtask

  task automatic test_overflow();
    int unsigned cyc, bsy;
    bit ok;
    start_conv(255);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || bus.bcd !== ref_bcd(255) || bus.overflow !== ref_ovf(255))
      $display("FAIL ovf_255: got ok=%b bcd=%h ovf=%b want %h %b",
               ok, bus.bcd, bus.overflow, ref_bcd(255), ref_ovf(255));
    else passes++;
    tick();
    checks++;
    if (bus.overflow !== ref_ovf(255))
      $display("FAIL ovf_hold: got %b want %b", bus.overflow, ref_ovf(255));
    else passes++;
    start_conv(99);
    wait_done(cyc, bsy, ok);
    checks++;
    if (!ok || bus.bcd !== ref_bcd(99) || bus.overflow !== 1'b0)
      $display("FAIL ovf_clear_99: got ok=%b bcd=%h ovf=%b want %h 0",
               ok, bus.bcd, bus.overflow, ref_bcd(99));
    else passes++;
    tick();
  endtask

  task automatic test_random();
    int unsigned cyc, bsy, v;
    bit ok;
    for (int n = 0; n < 24; n++) begin
      v = $urandom_range(0, (1 << WIDTH) - 1);
      start_conv(v);
      wait_done(cyc, bsy, ok);
      checks++;
      if (!ok || cyc != WIDTH || bus.bcd !== ref_bcd(v) || bus.overflow !== ref_ovf(v))
        $display("FAIL random_%0d: bin=%0d got ok=%b edges=%0d bcd=%h ovf=%b want %h %b",
                 n, v, ok, cyc, bus.bcd, bus.overflow, ref_bcd(v), ref_ovf(v));
      else passes++;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    reset_n   = 1'b0;
    repeat (3) tick();
    test_reset();
    test_latency();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
